// File: rtl/ddr_ser_pkg.sv
// rtl/ddr_ser_pkg.sv - shared state encoding and DQS patterns for the DQ burst serialiser
package ddr_ser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        POST = 2'd3
    } ser_state_e;

    typedef struct packed {
        logic oe;
        logic r;
        logic f;
    } dqs_pat_t;

    localparam dqs_pat_t DQS_OFF    = '{oe: 1'b0, r: 1'b0, f: 1'b0};
    localparam dqs_pat_t DQS_HOLD   = '{oe: 1'b1, r: 1'b0, f: 1'b0};
    localparam dqs_pat_t DQS_TOGGLE = '{oe: 1'b1, r: 1'b1, f: 1'b0};

    function automatic dqs_pat_t dqs_for(input ser_state_e s);
        case (s)
            PRE, POST: return DQS_HOLD;
            DATA:      return DQS_TOGGLE;
            default:   return DQS_OFF;
        endcase
    endfunction

endpackage

// File: rtl/ser_lane_shift.sv
// rtl/ser_lane_shift.sv - one DQ lane: burst shift register with registered rise/fall beat outputs
module ser_lane_shift #(
    parameter int BL = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          shift,
    input  logic          drive,
    input  logic [BL-1:0] load_data,
    output logic          dq_r,
    output logic          dq_f
);

    logic [BL-1:0] sr;
    logic [BL-1:0] sr_next;

    always_comb begin
        sr_next = sr;
        if (load) begin
            sr_next = load_data;
        end else if (shift) begin
            sr_next = {2'b00, sr[BL-1:2]};
        end
    end

    // Outputs are taken from the next shifter value so the beat lands in the cycle it is loaded for.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr   <= '0;
            dq_r <= 1'b0;
            dq_f <= 1'b0;
        end else begin
            sr   <= sr_next;
            dq_r <= drive & sr_next[0];
            dq_f <= drive & sr_next[1];
        end
    end

endmodule

// File: rtl/dq_burst_serialiser.sv
// rtl/dq_burst_serialiser.sv - multi-lane DDR write-burst serialiser with DQS/OE generation
module dq_burst_serialiser
    import ddr_ser_pkg::*;
#(
    parameter int LANES    = 8,
    parameter int BL       = 16,
    parameter int PRE_CYC  = 1,
    parameter int POST_CYC = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [LANES*BL-1:0] data_i,
    input  logic                chop_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [LANES-1:0]    dq_r_o,
    output logic [LANES-1:0]    dq_f_o,
    output logic                dq_oe_o,
    output logic                dqs_r_o,
    output logic                dqs_f_o,
    output logic                dqs_oe_o,
    output logic                burst_done_o,
    output logic                busy_o
);

    localparam int              BW        = $clog2(BL / 2);
    localparam logic [BW-1:0]   BEAT_LAST = BW'(BL / 2 - 1);
    localparam logic [BW-1:0]   BEAT_PEN  = BW'(BL / 2 - 2);
    localparam logic [BW-1:0]   CHOP_LAST = BW'((BL + 2) / 4 - 1);
    localparam logic [2:0]      PRE_LAST  = 3'(PRE_CYC - 1);
    localparam logic [2:0]      POST_LAST = 3'(POST_CYC - 1);

    ser_state_e            state;
    ser_state_e            nxt_state;
    logic [BW-1:0]         beat;
    logic [2:0]            cnt;
    logic [LANES*BL-1:0]   hold_data;
    logic                  hold_chop;
    logic                  hold_full;
    logic                  chop_cur;
    logic                  accept;
    logic                  last_beat;
    logic                  load;
    logic                  shift;
    logic                  enter_data;
    logic                  drive;

    assign hold_full = !ready_o;

    always_comb begin
        accept     = valid_i && ready_o;
        last_beat  = (state == DATA) && (beat == BEAT_LAST);
        load       = hold_full && ((state == IDLE) || last_beat);
        shift      = (state == DATA) && !last_beat;
        nxt_state  = state;
        case (state)
            IDLE: if (hold_full) nxt_state = (PRE_CYC == 0) ? DATA : PRE;
            PRE:  if (cnt == PRE_LAST) nxt_state = DATA;
            DATA: if (last_beat && !hold_full) nxt_state = (POST_CYC == 0) ? IDLE : POST;
            POST: if (cnt == POST_LAST) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
        // Every entry into a burst slot starts at beat 0, which always drives even when chopped.
        enter_data = (nxt_state == DATA) && ((state != DATA) || last_beat);
        drive      = enter_data || (shift && (!chop_cur || (beat < CHOP_LAST)));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            beat         <= '0;
            cnt          <= '0;
            ready_o      <= 1'b1;
            hold_chop    <= 1'b0;
            chop_cur     <= 1'b0;
            dq_oe_o      <= 1'b0;
            dqs_oe_o     <= 1'b0;
            dqs_r_o      <= 1'b0;
            dqs_f_o      <= 1'b0;
            burst_done_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state <= nxt_state;
            if (load) begin
                ready_o  <= 1'b1;
                chop_cur <= hold_chop;
            end else if (accept) begin
                ready_o   <= 1'b0;
                hold_data <= data_i;
                hold_chop <= chop_i;
            end
            if (enter_data) begin
                beat <= '0;
            end else if (shift) begin
                beat <= beat + 1'b1;
            end
            if (nxt_state != state) begin
                cnt <= '0;
            end else if ((state == PRE) || (state == POST)) begin
                cnt <= cnt + 3'd1;
            end
            {dqs_oe_o, dqs_r_o, dqs_f_o} <= dqs_for(nxt_state);
            dq_oe_o      <= drive;
            burst_done_o <= shift && (beat == BEAT_PEN);
            busy_o       <= (nxt_state != IDLE) || (!load && (accept || hold_full));
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ser_lane_shift #(.BL(BL)) u_lane (
            .clk       (clk_i),
            .rst       (rst_i),
            .load      (load),
            .shift     (shift),
            .drive     (drive),
            .load_data (hold_data[l*BL +: BL]),
            .dq_r      (dq_r_o[l]),
            .dq_f      (dq_f_o[l])
        );
    end

endmodule

// File: tb/tb_dq_burst_serialiser.sv
// tb/tb_dq_burst_serialiser.sv - directed self-checking bench for dq_burst_serialiser
module tb_dq_burst_serialiser;

    localparam logic [2:0] Q_OFF  = 3'b000;
    localparam logic [2:0] Q_HOLD = 3'b100;
    localparam logic [2:0] Q_TOG  = 3'b110;

    logic         clk = 1'b0;
    logic         rst, valid, valid0, chop;
    logic [127:0] data;

    logic         ready, dq_oe, dqs_r, dqs_f, dqs_oe, done, busy;
    logic [7:0]   dq_r, dq_f;
    logic         ready0, dq_oe0, dqs_r0, dqs_f0, dqs_oe0, done0, busy0;
    logic [7:0]   dq_r0, dq_f0;

    logic [20:0]  snap, snap0;
    int           checks = 0;
    int           errors = 0;

    assign snap  = {dq_r,  dq_f,  dq_oe,  dqs_oe,  dqs_r,  dqs_f,  done};
    assign snap0 = {dq_r0, dq_f0, dq_oe0, dqs_oe0, dqs_r0, dqs_f0, done0};

    always #5 clk = ~clk;

    dq_burst_serialiser dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .chop_i(chop), .valid_i(valid),
        .ready_o(ready), .dq_r_o(dq_r), .dq_f_o(dq_f), .dq_oe_o(dq_oe),
        .dqs_r_o(dqs_r), .dqs_f_o(dqs_f), .dqs_oe_o(dqs_oe),
        .burst_done_o(done), .busy_o(busy)
    );

    dq_burst_serialiser #(.LANES(8), .BL(16), .PRE_CYC(0), .POST_CYC(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .chop_i(chop), .valid_i(valid0),
        .ready_o(ready0), .dq_r_o(dq_r0), .dq_f_o(dq_f0), .dq_oe_o(dq_oe0),
        .dqs_r_o(dqs_r0), .dqs_f_o(dqs_f0), .dqs_oe_o(dqs_oe0),
        .burst_done_o(done0), .busy_o(busy0)
    );

    function automatic logic [20:0] mk(input logic [7:0] r, input logic [7:0] f,
                                       input logic oe, input logic [2:0] q, input logic dn);
        return {r, f, oe, q, dn};
    endfunction

    // rp/fp hold the hand-derived rise/fall bit of the lane for beat pair k in bit k.
    function automatic logic [20:0] beat_exp(input int lane, input logic [7:0] rp,
                                             input logic [7:0] fp, input int k);
        logic [7:0] one, r, f;
        one = 8'd1 << lane;
        r   = rp[k] ? one : 8'h00;
        f   = fp[k] ? one : 8'h00;
        return mk(r, f, 1'b1, Q_TOG, k == 7);
    endfunction

    task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_burst(input int lane, input logic [15:0] d);
        data = '0;
        data[lane*16 +: 16] = d;
    endtask

    task automatic run_single(input string tag, input int lane, input logic [15:0] d,
                              input logic [7:0] rp, input logic [7:0] fp);
        load_burst(lane, d);
        valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            valid = 1'b0;
            if (c == 1) begin
                chk1({tag, "_hold_ready"}, ready, 1'b0);
                chk({tag, "_c1"}, snap, '0);
            end else if (c == 2) begin
                chk({tag, "_pre"}, snap, mk(8'h00, 8'h00, 1'b0, Q_HOLD, 1'b0));
                chk1({tag, "_ready_back"}, ready, 1'b1);
            end else if (c <= 10) begin
                chk({tag, "_beat"}, snap, beat_exp(lane, rp, fp, c - 3));
            end else if (c == 11) begin
                chk({tag, "_post"}, snap, mk(8'h00, 8'h00, 1'b0, Q_HOLD, 1'b0));
            end else begin
                chk({tag, "_idle"}, snap, '0);
                chk1({tag, "_busy"}, busy, 1'b0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; valid0 = 1'b0; chop = 1'b0; data = '0;
        tick();
        tick();
        chk("rst_snap", snap, '0);
        chk1("rst_ready", ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_snap0", snap0, '0);
        chk1("rst_ready0", ready0, 1'b1);
        chk1("rst_dqs_oe", dqs_oe, 1'b0);
        rst = 1'b0;

        // A5C3 on lane 0: rise bits 1,0,0,1,1,1,0,0 and fall bits 1,0,0,1,0,0,1,1.
        run_single("single", 0, 16'hA5C3, 8'h39, 8'hC9);

        // Second burst handshaken in cycle 4 streams straight after the first.
        load_burst(0, 16'hA5C3);
        valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 4) begin
                load_burst(3, 16'h00FF);
                valid = 1'b1;
            end else begin
                valid = 1'b0;
            end
            if (c == 2)                 chk("seam_pre", snap, mk(8'h00, 8'h00, 1'b0, Q_HOLD, 1'b0));
            else if (c >= 3 && c <= 10) chk("seam_a", snap, beat_exp(0, 8'h39, 8'hC9, c - 3));
            else if (c >= 11 && c <= 18) chk("seam_b", snap, beat_exp(3, 8'h0F, 8'h0F, c - 11));
            else if (c == 19)           chk("seam_post", snap, mk(8'h00, 8'h00, 1'b0, Q_HOLD, 1'b0));
            else if (c == 20)           chk("seam_idle", snap, '0);
        end

        // Chopped all-ones burst: four driven cycles, four silent ones with DQS running.
        data = '1;
        chop = 1'b1;
        valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            valid = 1'b0;
            chop = 1'b0;
            if (c == 2)                chk("chop_pre", snap, mk(8'h00, 8'h00, 1'b0, Q_HOLD, 1'b0));
            else if (c >= 3 && c <= 6) chk("chop_drive", snap, mk(8'hFF, 8'hFF, 1'b1, Q_TOG, 1'b0));
            else if (c >= 7 && c <= 10) chk("chop_quiet", snap, mk(8'h00, 8'h00, 1'b0, Q_TOG, c == 10));
            else if (c == 11)          chk("chop_post", snap, mk(8'h00, 8'h00, 1'b0, Q_HOLD, 1'b0));
            else if (c == 12)          chk("chop_idle", snap, '0);
        end

        // No preamble or postamble on the second instance.
        load_burst(0, 16'hA5C3);
        valid0 = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            valid0 = 1'b0;
            if (c == 1)                chk("nopre_c1", snap0, '0);
            else if (c >= 2 && c <= 9) chk("nopre_beat", snap0, beat_exp(0, 8'h39, 8'hC9, c - 2));
            else                       chk("nopre_idle", snap0, '0);
            if (c == 10) chk1("nopre_busy", busy0, 1'b0);
        end

        // Reset in cycle 6 with a second burst waiting in the hold buffer.
        load_burst(0, 16'hA5C3);
        valid = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            valid = (c == 3);
            if (c == 3) load_burst(1, 16'hFFFF);
            rst = (c == 6);
            if (c >= 3 && c <= 6) chk("rstmid_beat", snap, beat_exp(0, 8'h39, 8'hC9, c - 3));
            if (c == 5) chk1("rstmid_holdfull", ready, 1'b0);
            if (c >= 7) chk("rstmid_quiet", snap, '0);
            if (c == 7) begin
                chk1("rstmid_ready", ready, 1'b1);
                chk1("rstmid_busy", busy, 1'b0);
            end
        end
        run_single("after_rst", 2, 16'h3333, 8'h55, 8'h55);

        // valid held while stalled with changing data: only the cycle-11 word is taken.
        load_burst(0, 16'hA5C3);
        valid = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            tick();
            valid = (c <= 2) || (c >= 6 && c <= 11);
            if (c <= 2)       load_burst(0, 16'h3333);
            else if (c <= 10) data = {4{$urandom()}};
            else if (c == 11) load_burst(0, 16'h0F0F);
            if (c >= 6 && c <= 10) chk1("stall_ready", ready, 1'b0);
            if (c == 11)           chk1("stall_ready_back", ready, 1'b1);
            if (c >= 3 && c <= 10)       chk("stall_a", snap, beat_exp(0, 8'h39, 8'hC9, c - 3));
            else if (c >= 11 && c <= 18) chk("stall_b", snap, beat_exp(0, 8'h55, 8'h55, c - 11));
            else if (c >= 19 && c <= 26) chk("stall_c", snap, beat_exp(0, 8'h33, 8'h33, c - 19));
            else if (c == 27)            chk("stall_post", snap, mk(8'h00, 8'h00, 1'b0, Q_HOLD, 1'b0));
            else if (c == 28)            chk("stall_idle", snap, '0);
        end

        // Handshake in the last DATA cycle is too late to be seamless.
        load_burst(0, 16'hA5C3);
        valid = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            tick();
            valid = (c == 10);
            if (c == 10) begin
                load_burst(5, 16'h0F0F);
                chk1("late_ready", ready, 1'b1);
            end
            if (c >= 3 && c <= 10)       chk("late_a", snap, beat_exp(0, 8'h39, 8'hC9, c - 3));
            else if (c == 11)            chk("late_post", snap, mk(8'h00, 8'h00, 1'b0, Q_HOLD, 1'b0));
            else if (c == 12) begin
                chk("late_gap", snap, {18'h0, Q_OFF});
                chk1("late_gap_busy", busy, 1'b1);
            end
            else if (c == 13)            chk("late_pre", snap, mk(8'h00, 8'h00, 1'b0, Q_HOLD, 1'b0));
            else if (c >= 14 && c <= 21) chk("late_b", snap, beat_exp(5, 8'h33, 8'h33, c - 14));
            else if (c == 22)            chk("late_post2", snap, mk(8'h00, 8'h00, 1'b0, Q_HOLD, 1'b0));
            else if (c == 23)            chk("late_idle", snap, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dq_burst_serialiser.md
# dq_burst_serialiser

Parametrised multi-lane DDR write-burst serialiser for the DDR5 controller write datapath. It accepts one full burst per lane through a valid/ready handshake and emits it as rise/fall bit pairs for the DQ output cells. It generates the matching DQS pattern and output enables, including preamble and postamble. Back-to-back bursts are streamed seamlessly, and burst-chop is supported. Everything runs in one clock domain; the DDR muxing itself is left to the downstream output-cell primitive.

## Interface
- `LANES`, 8: number of DQ lanes.
- `BL`, 16: burst length in beats per lane. Must be even and ≥4.
- `PRE_CYC`, 1: preamble length in clock cycles, 0..7.
- `POST_CYC`, 1: postamble length in clock cycles, 0..7.

Ports:
- `clk_i`  in  1  single clock. All logic is posedge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `data_i`  in  LANES*BL  burst data. Lane l, beat b = `data_i[l*BL+b]`.
- `chop_i`  in  1  burst-chop: only beats 0..BL/2-1 are driven. Sampled with data.
- `valid_i`  in  1  burst offered.
- `ready_o`  out  1  hold buffer empty.
- `dq_r_o`  out  LANES  beat driven in the rising half.
- `dq_f_o`  out  LANES  beat driven in the falling half.
- `dq_oe_o`  out  1  DQ output enable.
- `dqs_r_o`, `dqs_f_o`  out  1 each  strobe value in the rising/falling half.
- `dqs_oe_o`  out  1  DQS output enable.
- `burst_done_o`  out  1  single-cycle pulse in the last cycle of each burst slot.
- `busy_o`  out  1  state ≠ IDLE or hold full.

## Operation
- **Handshake:** transfer occurs when `valid_i & ready_o`. Data and `chop_i` go to a one-entry hold buffer. `ready_o = !hold_full`.
- **Shifter:** a per-lane shift register loads from the hold buffer. The hold buffer empties in the same cycle.
- **Beat order:** each DATA cycle outputs beat 2k on `dq_r_o` and beat 2k+1 on `dq_f_o`, k = 0..BL/2-1, with beat 0 first.
- **FSM states:** IDLE, PRE, DATA, POST.
  - **IDLE:** if hold full, load the shifter and go to PRE. If PRE_CYC=0, go directly to DATA.
  - **PRE:** lasts PRE_CYC cycles. `dqs_oe_o=1`, dqs_r=0, dqs_f=0, `dq_oe_o=0`.
  - **DATA:** lasts BL/2 cycles per burst. `dq_oe_o=1`, `dqs_oe_o=1`, dqs_r=1, dqs_f=0.
  - **Leaving DATA (last cycle):** if hold is full, reload the shifter and stay in DATA (seamless; no pre/postamble). Otherwise go to POST, or to IDLE if POST_CYC=0.
  - **POST:** lasts POST_CYC cycles. `dqs_oe_o=1`, dqs_r=0, dqs_f=0, `dq_oe_o=0`. Then go to IDLE. A burst accepted during POST waits for POST to end, then goes through the full PRE.
- **Chop:** a chopped burst still occupies BL/2 DATA cycles.
  - The first BL/4 cycles (rounded up) drive data.
  - The remaining cycles force `dq_oe_o=0` and DQ outputs to 0, while DQS keeps toggling.
- **Idle values:** outside DATA, `dq_r_o`/`dq_f_o` are 0. Outside PRE/DATA/POST, `dqs_oe_o=0` and dqs_r/f=0.
- **Beat counter:** width `$clog2(BL/2)`; terminal count BL/2-1. The preamble/postamble counter is 3 bits.

## Timing
- All outputs are registered. Cycle n is the interval after clock edge n; the handshake happens in cycle 0.
- Latency from IDLE:
  - hold full in cycle 1;
  - PRE outputs in cycles 2..1+PRE_CYC;
  - beats in cycles 2+PRE_CYC..1+PRE_CYC+BL/2;
  - `burst_done_o` in cycle 1+PRE_CYC+BL/2.
- `ready_o` rises in the cycle after the hold buffer is drained. Any burst handshaken before the last DATA cycle of the current burst streams seamlessly.
- A handshake in the same cycle as the last DATA cycle is too late. It is not seamless and sees POST then PRE.
- `valid_i` held high while `ready_o=0` causes no transfer. The data must be held stable by the producer.
- **Reset values:** state IDLE, hold empty, `ready_o=1`, all other outputs 0.
- **Reset mid-burst:** applies at the next edge. The in-flight burst and the hold contents are discarded, with no postamble and no `burst_done_o`.

## Structure
- **Package `ddr_ser_pkg`:** state enum (IDLE/PRE/DATA/POST) and the DQS pattern constants for each state.
- **Sub-module `ser_lane_shift`** (parameter BL): loads BL bits, shifts by 2 per enable, and presents bits [1:0]. Instantiated LANES times via generate.
- **Top level:** holds the FSM, counters, hold buffer and enable logic.

## Test plan
- LANES=8, BL=16, PRE=POST=1; lane 0 = 16'hA5C3, other lanes 0 → PRE in cycle 2. Beats in cycles 3..10: dq_r[0]/dq_f[0] = (1,1),(0,0),(0,0),(1,1),(1,0),(1,0),(0,1),(0,1). `burst_done_o` in cycle 10. POST in cycle 11. IDLE from cycle 12.
- Two bursts, the second handshaken in cycle 4 → 16 contiguous DATA cycles (3..18), `burst_done_o` in cycles 10 and 18, and no PRE or POST between the bursts.
- `chop_i=1`, all-ones data → `dq_oe_o=1` and DQ=1 in cycles 3..6. `dq_oe_o=0` and DQ=0 in cycles 7..10 while DQS toggles. `burst_done_o` in cycle 10.
- PRE_CYC=0, POST_CYC=0 → DATA in cycles 2..9, IDLE in cycle 10, and `dqs_oe_o` high only in cycles 2..9.
- `rst_i` asserted in cycle 6 with the hold buffer full → all outputs 0 and `ready_o=1` from cycle 7. No `burst_done_o`. A new burst afterwards behaves as from reset.
- `valid_i` high while `ready_o=0` for 5 cycles with changing data → only the data present when `ready_o` returns is transmitted.
